tthbif_cfg_ctrl: RTL and testbench

TTHBIF_CFG_CTRL -- requirements
Module: tthbif_cfg_ctrl

---
 rtl/tthbif_pkg.sv | 32 +++
 rtl/tthbif_cfg_ctrl_if.sv | 26 ++
 rtl/tthbif_cfg_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tthbif_cfg_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tthbif_pkg.sv
// Shared constants and types for the tthbif configuration controller:
// command opcodes, response codes, register addresses and FSM states.
package tthbif_pkg;

  // Command opcodes (ASCII 'W' and 'R')
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  // Single-byte responses
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // Register map
  localparam logic [7:0] REG_RX_FLOP = 8'h00;
  localparam logic [7:0] REG_RX_COMB = 8'h01;
  localparam logic [7:0] REG_TX_FLOP = 8'h02;
  localparam logic [7:0] REG_TX_COMB = 8'h03;
  localparam logic [7:0] REG_CTRL    = 8'h04;
  localparam logic [7:0] REG_ID      = 8'h05;

  // Constant returned by the read-only ID register
  localparam logic [7:0] ID_VALUE = 8'hA5;

  // Command parser states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/tthbif_cfg_ctrl_if.sv
// Byte-stream link between the UART and the configuration controller.
// master = UART side (delivers received bytes, accepts response bytes),
// slave  = controller side.
interface tthbif_cfg_ctrl_if;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic       tx_data_valid;
  logic [7:0] tx_data;
  logic       tx_data_ready;

  modport master (
    output rx_data_valid,
    output rx_data,
    output tx_data_ready,
    input  tx_data_valid,
    input  tx_data
  );

  modport slave (
    input  rx_data_valid,
    input  rx_data,
    input  tx_data_ready,
    output tx_data_valid,
    output tx_data
  );
endinterface

// File: rtl/tthbif_cfg_ctrl.sv
// UART-driven register block that sets the tthbif tap selects and link
// enable. Parses 'W' addr data / 'R' addr commands and answers every
// command with exactly one byte (ACK, NAK or read data). Incomplete
// commands are abandoned silently after TIMEOUT_CYCLES idle cycles.
module tthbif_cfg_ctrl
  import tthbif_pkg::*;
#(
  parameter int TAP_SEL_W      = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_data_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 tx_data_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_data_ready_i,
  output logic [TAP_SEL_W-1:0] rx_flop_tap_sel_o,
  output logic [TAP_SEL_W-1:0] rx_comb_tap_sel_o,
  output logic [TAP_SEL_W-1:0] tx_flop_tap_sel_o,
  output logic [TAP_SEL_W-1:0] tx_comb_tap_sel_o,
  output logic                 link_en_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  state_e               state_q, state_d;
  logic                 op_write_q, op_write_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TAP_SEL_W-1:0] rx_flop_q, rx_flop_d;
  logic [TAP_SEL_W-1:0] rx_comb_q, rx_comb_d;
  logic [TAP_SEL_W-1:0] tx_flop_q, tx_flop_d;
  logic [TAP_SEL_W-1:0] tx_comb_q, tx_comb_d;
  logic                 link_en_q, link_en_d;
  logic [7:0]           rd_data;

  // Read mux addressed by the incoming byte; unmapped addresses read as NAK
  always_comb begin
    rd_data = RSP_NAK;
    case (rx_data_i)
      REG_RX_FLOP: rd_data = 8'(rx_flop_q);
      REG_RX_COMB: rd_data = 8'(rx_comb_q);
      REG_TX_FLOP: rd_data = 8'(tx_flop_q);
      REG_TX_COMB: rd_data = 8'(tx_comb_q);
      REG_CTRL:    rd_data = {7'b0, link_en_q};
      REG_ID:      rd_data = ID_VALUE;
      default:     rd_data = RSP_NAK;
    endcase
  end

  // Command parser: next state, register writes, response byte, timeout
  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    rx_flop_d  = rx_flop_q;
    rx_comb_d  = rx_comb_q;
    tx_flop_d  = tx_flop_q;
    tx_comb_d  = tx_comb_q;
    link_en_d  = link_en_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_data_valid_i) begin
          if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
            op_write_d = (rx_data_i == OP_WRITE);
            state_d    = ADDR;
          end else begin
            tx_data_d = RSP_NAK;
            state_d   = RESP;
          end
        end
      end

      ADDR: begin
        if (rx_data_valid_i) begin
          cnt_d = '0;
          if (op_write_q) begin
            addr_d  = rx_data_i;
            state_d = DATA;
          end else begin
            tx_data_d = rd_data;
            state_d   = RESP;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (rx_data_valid_i) begin
          cnt_d     = '0;
          tx_data_d = RSP_ACK;
          state_d   = RESP;
          case (addr_q)
            REG_RX_FLOP: rx_flop_d = rx_data_i[TAP_SEL_W-1:0];
            REG_RX_COMB: rx_comb_d = rx_data_i[TAP_SEL_W-1:0];
            REG_TX_FLOP: tx_flop_d = rx_data_i[TAP_SEL_W-1:0];
            REG_TX_COMB: tx_comb_d = rx_data_i[TAP_SEL_W-1:0];
            REG_CTRL:    link_en_d = rx_data_i[0];
            default:     tx_data_d = RSP_NAK;
          endcase
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        // Incoming bytes are ignored here; hold the byte until accepted
        cnt_d = '0;
        if (tx_data_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    tx_valid_d = (state_d == RESP);
  end

  // State and register file, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      addr_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cnt_q      <= '0;
      rx_flop_q  <= '1;
      rx_comb_q  <= '1;
      tx_flop_q  <= '1;
      tx_comb_q  <= '1;
      link_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cnt_q      <= cnt_d;
      rx_flop_q  <= rx_flop_d;
      rx_comb_q  <= rx_comb_d;
      tx_flop_q  <= tx_flop_d;
      tx_comb_q  <= tx_comb_d;
      link_en_q  <= link_en_d;
    end
  end

  assign tx_data_valid_o   = tx_valid_q;
  assign tx_data_o         = tx_data_q;
  assign rx_flop_tap_sel_o = rx_flop_q;
  assign rx_comb_tap_sel_o = rx_comb_q;
  assign tx_flop_tap_sel_o = tx_flop_q;
  assign tx_comb_tap_sel_o = tx_comb_q;
  assign link_en_o         = link_en_q;

endmodule

// File: tb/tb_tthbif_cfg_ctrl.sv
// Directed bench for tthbif_cfg_ctrl: inputs change on the falling edge,
// outputs are sampled on the falling edge, half a cycle after the
// capturing rising edge.
module tb_tthbif_cfg_ctrl;
  import tthbif_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] rx_flop, rx_comb, tx_flop, tx_comb;
  logic link_en;
  int vectors = 0;
  int miscompares = 0;

  tthbif_cfg_ctrl_if bus ();

  tthbif_cfg_ctrl #(.TAP_SEL_W(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .rx_data_valid_i   (bus.rx_data_valid),
    .rx_data_i         (bus.rx_data),
    .tx_data_valid_o   (bus.tx_data_valid),
    .tx_data_o         (bus.tx_data),
    .tx_data_ready_i   (bus.tx_data_ready),
    .rx_flop_tap_sel_o (rx_flop),
    .rx_comb_tap_sel_o (rx_comb),
    .tx_flop_tap_sel_o (tx_flop),
    .tx_comb_tap_sel_o (tx_comb),
    .link_en_o         (link_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after capture
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data_valid = 1'b1;
    bus.rx_data       = b;
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = 8'h00;
  endtask

  // Response must be visible now; with ready high it is gone one cycle later
  task automatic expect_resp(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(bus.tx_data_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.tx_data), 32'(exp));
    @(negedge clk);
    check({tag, "_done"}, 32'(bus.tx_data_valid), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("silent_no_valid", 32'(bus.tx_data_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = 8'h00;
    bus.tx_data_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rx_flop", 32'(rx_flop), 32'h3);
    check("rst_rx_comb", 32'(rx_comb), 32'h3);
    check("rst_tx_flop", 32'(tx_flop), 32'h3);
    check("rst_tx_comb", 32'(tx_comb), 32'h3);
    check("rst_link_en", 32'(link_en), 32'h0);
    check("rst_valid", 32'(bus.tx_data_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(bus.tx_data_valid), 32'h0);

    // Write tx_flop with 0xF1 -> low bits 01, then read it back
    send_byte(OP_WRITE);
    send_byte(8'h02);
    check("w_mid_no_valid", 32'(bus.tx_data_valid), 32'h0);
    check("w_mid_tx_flop", 32'(tx_flop), 32'h3);
    send_byte(8'hF1);
    check("w_tx_flop", 32'(tx_flop), 32'h1);
    check("w_rx_flop_keep", 32'(rx_flop), 32'h3);
    expect_resp("w_ack", RSP_ACK);
    send_byte(OP_READ);
    send_byte(8'h02);
    expect_resp("r_tx_flop", 8'h01);

    // Invalid commands
    send_byte(8'h41);
    expect_resp("bad_op", RSP_NAK);
    send_byte(OP_WRITE);
    send_byte(8'h05);
    send_byte(8'h00);
    expect_resp("w_id", RSP_NAK);
    send_byte(OP_READ);
    send_byte(8'h05);
    expect_resp("r_id", 8'hA5);
    send_byte(OP_READ);
    send_byte(8'h07);
    expect_resp("r_bad_addr", RSP_NAK);
    send_byte(OP_WRITE);
    send_byte(8'h09);
    send_byte(8'h01);
    expect_resp("w_bad_addr", RSP_NAK);

    // Write rx_comb and tx_comb, read back
    send_byte(OP_WRITE);
    send_byte(8'h01);
    send_byte(8'hFE);
    check("w_rx_comb", 32'(rx_comb), 32'h2);
    expect_resp("w_rx_comb_ack", RSP_ACK);
    send_byte(OP_READ);
    send_byte(8'h01);
    expect_resp("r_rx_comb", 8'h02);
    send_byte(OP_WRITE);
    send_byte(8'h03);
    send_byte(8'h00);
    check("w_tx_comb", 32'(tx_comb), 32'h0);
    expect_resp("w_tx_comb_ack", RSP_ACK);

    // Backpressure: hold ready low for 10 cycles, inject a byte meanwhile
    bus.tx_data_ready = 1'b0;
    send_byte(OP_WRITE);
    send_byte(8'h00);
    send_byte(8'h02);
    check("bp_rx_flop", 32'(rx_flop), 32'h2);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(bus.tx_data_valid), 32'h1);
      check("bp_data", 32'(bus.tx_data), 32'h06);
      bus.rx_data_valid = (i == 3);
      bus.rx_data       = (i == 3) ? OP_WRITE : 8'h00;
      @(negedge clk);
    end
    bus.rx_data_valid = 1'b0;
    bus.tx_data_ready = 1'b1;
    check("bp_still_valid", 32'(bus.tx_data_valid), 32'h1);
    @(negedge clk);
    check("bp_released", 32'(bus.tx_data_valid), 32'h0);
    send_byte(OP_READ);
    send_byte(8'h00);
    expect_resp("bp_dropped_byte", 8'h02);

    // Timeout: 16 silent cycles in DATA abandon the write
    send_byte(OP_WRITE);
    send_byte(8'h04);
    idle_cycles(16);
    send_byte(8'h01);
    check("to_link_en", 32'(link_en), 32'h0);
    expect_resp("to_then_nak", RSP_NAK);
    send_byte(OP_READ);
    send_byte(8'h05);
    expect_resp("to_r_id", 8'hA5);

    // A byte on the timeout cycle itself still completes the command
    send_byte(OP_WRITE);
    send_byte(8'h04);
    idle_cycles(15);
    send_byte(8'h01);
    check("to_edge_link_en", 32'(link_en), 32'h1);
    expect_resp("to_edge_ack", RSP_ACK);
    send_byte(OP_READ);
    send_byte(8'h04);
    expect_resp("r_ctrl", 8'h01);

    // Timeout while waiting for the address of a read
    send_byte(OP_READ);
    idle_cycles(16);
    send_byte(8'h05);
    expect_resp("to_addr_nak", RSP_NAK);

    // Reset mid-command abandons it
    send_byte(OP_WRITE);
    send_byte(8'h00);
    rst_n = 1'b0;
    #1;
    check("rst_mid_link_en", 32'(link_en), 32'h0);
    check("rst_mid_rx_flop", 32'(rx_flop), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h00);
    check("rst_mid_rx_flop_keep", 32'(rx_flop), 32'h3);
    expect_resp("rst_mid_nak", RSP_NAK);

    // Reset during RESP drops the pending response immediately
    bus.tx_data_ready = 1'b0;
    send_byte(8'h41);
    check("rst_resp_pending", 32'(bus.tx_data_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_resp_drop", 32'(bus.tx_data_valid), 32'h0);
    check("rst_resp_data", 32'(bus.tx_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.tx_data_ready = 1'b1;
    @(negedge clk);
    check("rst_resp_idle", 32'(bus.tx_data_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
